rom_sdram_writer: RTL and testbench
===================================

Name: rom_sdram_writer

Overview:
- Consumer side of the ROM load path.
- Accepts the word-addressed write strobes, addresses and 16-bit data that the ROM loader produces for SDRAM-resident regions (68k, tiles, sprites).
- Buffers them in a small FIFO and replays each entry to the SDRAM controller over a req/ack handshake.
- Back-pressures hps_io through ioctl_wait so that no download word is lost while SDRAM is busy.

Parameters:
- DEPTH, 4: FIFO entries; power of two, >= 2.
- AW, 26: width of the word address.
- WAIT_LVL, DEPTH-1: FIFO occupancy at or above which ioctl_wait is asserted.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- load_en  in  1  ROM download in progress (ioctl_download & index==ROM).
- wr_en  in  1  one-cycle write strobe (OR of the 68k, tiles and sprites write enables).
- wr_addr  in  AW  word address of the write.
- wr_data  in  16  data word (ioctl_dout, registered alongside wr_addr).
- ioctl_wait  out  1  stall request to hps_io.
- sdram_req  out  1  write request to the SDRAM controller.
- sdram_addr  out  AW  word address; held while sdram_req=1.
- sdram_din  out  16  data; held while sdram_req=1.
- sdram_ack  in  1  one-cycle completion pulse from the SDRAM controller.
- busy  out  1  FIFO non-empty or request outstanding.
- overflow  out  1  sticky: a write arrived while the FIFO was full.

Behaviour:
- Reset (async, reset_n=0):
  - FIFO pointers and count = 0; state = IDLE.
  - sdram_req=0, sdram_addr=0, sdram_din=0, ioctl_wait=0, busy=0, overflow=0.
  - Reset mid-transfer discards all FIFO contents and any outstanding request with no further action. A late sdram_ack after reset is ignored because the state is IDLE.
- FIFO:
  - Push when wr_en=1 and count<DEPTH: store {wr_addr, wr_data}, wr_ptr++ (mod DEPTH).
  - Pop occurs in the cycle the state machine loads an entry into the output registers.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Push with count==DEPTH (and no pop that cycle): word dropped, overflow<=1. overflow clears only on reset.
  - Pointers wrap modulo DEPTH. count is log2(DEPTH)+1 bits wide.
- wr_en is honoured regardless of load_en; load_en gates only ioctl_wait.
- State machine:
  - IDLE: if count>0, load head into sdram_addr/sdram_din, pop, set sdram_req=1, go to REQ. Latency: word pushed at edge k produces sdram_req=1 after edge k+1.
  - REQ: sdram_req, sdram_addr and sdram_din are held stable. On sdram_ack=1:
    - if count>0 (counting a push in that same cycle as not yet visible): load the next head, keep sdram_req=1, stay in REQ (back-to-back, no idle cycle).
    - otherwise sdram_req<=0 and go to IDLE.
  - sdram_ack seen in IDLE is ignored.
- ioctl_wait:
  - Registered: ioctl_wait <= load_en & (count_next >= WAIT_LVL), where count_next is the post-update occupancy.
  - It deasserts one cycle after occupancy drops below WAIT_LVL.
  - With load_en=0, ioctl_wait=0, but queued entries still drain.
- busy = (count!=0) | sdram_req, registered.
- Arithmetic: no address translation; wr_addr passes through unchanged at AW bits.

Test Plan:
- Single write: wr_en pulse, addr=0x1000000>>1=0x0800000, data=0xBEEF, ack 3 cycles after req → sdram_req high the cycle after push with addr 0x0800000 / din 0xBEEF. req drops the cycle after ack. busy 1→0. overflow=0.
- Back-to-back drain: 4 pushes on consecutive cycles, ack held off 10 cycles then ack every cycle → entries appear in push order; ioctl_wait rises when count reaches 3 (load_en=1) and falls after the first pop drops count below 3; sdram_req stays high continuously across the 4 acks.
- Overflow: ack tied low, 6 pushes → 1 entry in the output register, 4 in the FIFO, 1 dropped; overflow=1 and stays 1 after draining; data order 0..4 preserved.
- Simultaneous push and pop: count=2, push in the same cycle as ack → count remains 2; the next request carries the oldest remaining entry; no data corruption at pointer wrap (run 17 writes through DEPTH=4).
- Reset mid-operation: reset_n=0 while sdram_req=1 and count=3 → all outputs 0 immediately (async); after release, a stray sdram_ack produces no request; a new push behaves as in the single-write test.
- load_en gating: load_en=0, FIFO filled to 4 → ioctl_wait stays 0; set load_en=1 → ioctl_wait=1 on the next cycle.

Source files
------------

// File: rtl/rom_sdram_writer.sv
// ROM-load write buffer: queues download words in a small FIFO and replays them
// to the SDRAM controller over req/ack, stalling hps_io via ioctl_wait when nearly full.
module rom_sdram_writer #(
  parameter int DEPTH    = 4,
  parameter int AW       = 26,
  parameter int WAIT_LVL = DEPTH - 1
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          load_en,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  output logic          ioctl_wait,
  output logic          sdram_req,
  output logic [AW-1:0] sdram_addr,
  output logic [15:0]   sdram_din,
  input  logic          sdram_ack,
  output logic          busy,
  output logic          overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t          state, state_next;
  logic [AW+15:0]  mem [DEPTH];
  logic [AW+15:0]  head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_next;
  logic            push, pop, req_next;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Count seen here excludes a push landing in the same cycle, so it is not yet poppable.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count != '0) state_next = REQ;
      REQ:     if (sdram_ack && count == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = (count != '0);
      REQ:     pop = sdram_ack && (count != '0);
      default: pop = 1'b0;
    endcase
    req_next = (state_next == REQ);
  end

  // A full FIFO still accepts a word when an entry leaves in the same cycle.
  assign push       = wr_en && ((count != CW'(DEPTH)) || pop);
  assign count_next = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= {wr_addr, wr_data};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
      if (wr_en && !push) overflow <= 1'b1;
    end
  end

  // Address and data only change on a pop, so they stay stable while a request is pending.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      sdram_din  <= '0;
      ioctl_wait <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sdram_req  <= req_next;
      if (pop) begin
        sdram_addr <= head[AW+15:16];
        sdram_din  <= head[15:0];
      end
      ioctl_wait <= load_en && (count_next >= CW'(WAIT_LVL));
      busy       <= (count_next != '0) || req_next;
    end
  end

endmodule

// File: tb/tb_rom_sdram_writer.sv
// Self-checking bench for rom_sdram_writer: a small occupancy model tracks control
// outputs while a scoreboard queue holds accepted words until the SDRAM side acks them.
module tb_rom_sdram_writer;

  localparam int DEPTH    = 4;
  localparam int AW       = 26;
  localparam int WAIT_LVL = DEPTH - 1;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          load_en = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [15:0]   wr_data = '0;
  logic          ioctl_wait;
  logic          sdram_req;
  logic [AW-1:0] sdram_addr;
  logic [15:0]   sdram_din;
  logic          sdram_ack = 1'b0;
  logic          busy;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  logic [AW+15:0] exp_q[$];
  logic [AW+15:0] exp_word;
  int   m_count = 0;
  logic m_req = 1'b0, m_ovf = 1'b0, m_wait = 1'b0, m_busy = 1'b0;

  rom_sdram_writer #(.DEPTH(DEPTH), .AW(AW), .WAIT_LVL(WAIT_LVL)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .load_en(load_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ioctl_wait(ioctl_wait), .sdram_req(sdram_req), .sdram_addr(sdram_addr),
    .sdram_din(sdram_din), .sdram_ack(sdram_ack), .busy(busy), .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  // One clock of stimulus; accepted words go to the scoreboard, control state to the model.
  task automatic apply_stimulus(input logic w, input logic [AW-1:0] a,
                                input logic [15:0] d, input logic k);
    logic pop, push_ok;
    wr_en = w; wr_addr = a; wr_data = d; sdram_ack = k;
    @(posedge clk_sys);
    pop     = (m_count > 0) && (!m_req || k);
    push_ok = w && ((m_count < DEPTH) || pop);
    if (pop) m_req = 1'b1;
    else if (k && m_req) m_req = 1'b0;
    if (push_ok) exp_q.push_back({a, d});
    else if (w) m_ovf = 1'b1;
    m_count = m_count + int'(push_ok) - int'(pop);
    m_wait  = load_en && (m_count >= WAIT_LVL);
    m_busy  = (m_count != 0) || m_req;
    #1;
    wr_en = 1'b0; sdram_ack = 1'b0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_count = 0; m_req = 0; m_ovf = 0; m_wait = 0; m_busy = 0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({sdram_req, ioctl_wait, busy, overflow} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_ctrl: got %b expected 0000", {sdram_req, ioctl_wait, busy, overflow});
    end
    checks++;
    if ({sdram_addr, sdram_din} !== '0) begin
      errors++; $display("[TB] FAIL reset_data: got %h/%h expected 0/0", sdram_addr, sdram_din);
    end
    @(negedge clk_sys);
    reset_n = 1'b1;
  endtask

  task automatic test_single_write();
    apply_stimulus(1'b1, 26'h0800000, 16'hBEEF, 1'b0);
    checks++;
    if (sdram_req !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL single_latency: req=%b busy=%b expected req=0 busy=1", sdram_req, busy);
    end
    apply_stimulus(1'b0, '0, '0, 1'b0);
    checks++;
    if (sdram_req !== 1'b1 || sdram_addr !== 26'h0800000 || sdram_din !== 16'hBEEF) begin
      errors++; $display("[TB] FAIL single_req: req=%b addr=%h din=%h expected 1 0800000 beef", sdram_req, sdram_addr, sdram_din);
    end
    apply_stimulus(1'b0, '0, '0, 1'b0);
    apply_stimulus(1'b0, '0, '0, 1'b0);
    exp_word = exp_q.pop_front();
    checks++;
    if ({sdram_addr, sdram_din} !== exp_word) begin
      errors++; $display("[TB] FAIL single_ack_data: got %h expected %h", {sdram_addr, sdram_din}, exp_word);
    end
    apply_stimulus(1'b0, '0, '0, 1'b1);
    checks++;
    if (sdram_req !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("[TB] FAIL single_done: req=%b busy=%b ovf=%b expected 000", sdram_req, busy, overflow);
    end
  endtask

  task automatic test_back_to_back();
    load_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, AW'(26'h100 + i), 16'hA000 + 16'(i), 1'b0);
      checks++;
      if (ioctl_wait !== m_wait) begin
        errors++; $display("[TB] FAIL b2b_wait_fill%0d: got %b expected %b", i, ioctl_wait, m_wait);
      end
    end
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_word = exp_q.pop_front();
      checks++;
      if (sdram_req !== 1'b1 || {sdram_addr, sdram_din} !== exp_word) begin
        errors++; $display("[TB] FAIL b2b_ack%0d: req=%b got %h expected %h", i, sdram_req, {sdram_addr, sdram_din}, exp_word);
      end
      apply_stimulus(1'b0, '0, '0, 1'b1);
      checks++;
      if (ioctl_wait !== m_wait || sdram_req !== m_req || busy !== m_busy) begin
        errors++; $display("[TB] FAIL b2b_after%0d: wait/req/busy=%b%b%b expected %b%b%b",
                           i, ioctl_wait, sdram_req, busy, m_wait, m_req, m_busy);
      end
    end
    load_en = 1'b0;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) apply_stimulus(1'b1, AW'(26'h2000 + i), 16'(i), 1'b0);
    checks++;
    if (overflow !== 1'b1 || m_count != DEPTH) begin
      errors++; $display("[TB] FAIL ovf_set: ovf=%b model_count=%0d expected 1/%0d", overflow, m_count, DEPTH);
    end
    for (int i = 0; i < 5; i++) begin
      exp_word = exp_q.pop_front();
      checks++;
      if ({sdram_addr, sdram_din} !== exp_word) begin
        errors++; $display("[TB] FAIL ovf_order%0d: got %h expected %h", i, {sdram_addr, sdram_din}, exp_word);
      end
      apply_stimulus(1'b0, '0, '0, 1'b1);
    end
    checks++;
    if (overflow !== 1'b1 || sdram_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL ovf_sticky: ovf=%b req=%b busy=%b expected 1 0 0", overflow, sdram_req, busy);
    end
  endtask

  task automatic test_simultaneous_wrap();
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, AW'(26'h3000 + i), 16'h5A00 + 16'(i), 1'b0);
    for (int i = 3; i < 17; i++) begin
      exp_word = exp_q.pop_front();
      checks++;
      if (sdram_req !== 1'b1 || {sdram_addr, sdram_din} !== exp_word) begin
        errors++; $display("[TB] FAIL simul_data%0d: req=%b got %h expected %h", i, sdram_req, {sdram_addr, sdram_din}, exp_word);
      end
      apply_stimulus(1'b1, AW'(26'h3000 + i), 16'h5A00 + 16'(i), 1'b1);
    end
    checks++;
    if (m_count != 2 || busy !== 1'b1 || ioctl_wait !== 1'b0) begin
      errors++; $display("[TB] FAIL simul_level: model_count=%0d busy=%b wait=%b expected 2 1 0", m_count, busy, ioctl_wait);
    end
    while (exp_q.size() > 0) begin
      exp_word = exp_q.pop_front();
      checks++;
      if ({sdram_addr, sdram_din} !== exp_word) begin
        errors++; $display("[TB] FAIL simul_drain: got %h expected %h", {sdram_addr, sdram_din}, exp_word);
      end
      apply_stimulus(1'b0, '0, '0, 1'b1);
    end
    checks++;
    if (sdram_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL simul_idle: req=%b busy=%b expected 0 0", sdram_req, busy);
    end
  endtask

  task automatic test_reset_mid();
    load_en = 1'b1;
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, AW'(26'h4000 + i), 16'hC000 + 16'(i), 1'b0);
    checks++;
    if (sdram_req !== 1'b1 || ioctl_wait !== 1'b1) begin
      errors++; $display("[TB] FAIL rst_pre: req=%b wait=%b expected 1 1", sdram_req, ioctl_wait);
    end
    #1;
    reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({sdram_req, ioctl_wait, busy, overflow, sdram_addr, sdram_din} !== '0) begin
      errors++; $display("[TB] FAIL rst_async: req=%b wait=%b busy=%b ovf=%b addr=%h din=%h expected all 0",
                         sdram_req, ioctl_wait, busy, overflow, sdram_addr, sdram_din);
    end
    load_en = 1'b0;
    #1;
    reset_n = 1'b1;
    apply_stimulus(1'b0, '0, '0, 1'b1);
    apply_stimulus(1'b0, '0, '0, 1'b0);
    checks++;
    if (sdram_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_stray_ack: req=%b busy=%b expected 0 0", sdram_req, busy);
    end
    apply_stimulus(1'b1, 26'h0800000, 16'hBEEF, 1'b0);
    apply_stimulus(1'b0, '0, '0, 1'b0);
    exp_word = exp_q.pop_front();
    checks++;
    if (sdram_req !== 1'b1 || {sdram_addr, sdram_din} !== exp_word) begin
      errors++; $display("[TB] FAIL rst_repush: req=%b got %h expected %h", sdram_req, {sdram_addr, sdram_din}, exp_word);
    end
    apply_stimulus(1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_load_en_gating();
    load_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, AW'(26'h5000 + i), 16'h7700 + 16'(i), 1'b0);
      checks++;
      if (ioctl_wait !== 1'b0) begin
        errors++; $display("[TB] FAIL gate_off%0d: wait=%b expected 0", i, ioctl_wait);
      end
    end
    load_en = 1'b1;
    apply_stimulus(1'b0, '0, '0, 1'b0);
    checks++;
    if (ioctl_wait !== 1'b1 || overflow !== 1'b0) begin
      errors++; $display("[TB] FAIL gate_on: wait=%b ovf=%b expected 1 0", ioctl_wait, overflow);
    end
    load_en = 1'b0;
    while (exp_q.size() > 0) begin
      exp_word = exp_q.pop_front();
      checks++;
      if ({sdram_addr, sdram_din} !== exp_word) begin
        errors++; $display("[TB] FAIL gate_drain: got %h expected %h", {sdram_addr, sdram_din}, exp_word);
      end
      apply_stimulus(1'b0, '0, '0, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_simultaneous_wrap();
    test_load_en_gating();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
